// File: rtl/exe_muldiv_sequencer_pkg.sv
// rtl/exe_muldiv_sequencer_pkg.sv - shared encodings for the iterative mul/div sequencer
package exe_muldiv_sequencer_pkg;

   localparam int DEFAULT_WIDTH = 32;

   // op[1] selects divide, op[0] selects signed
   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/exe_muldiv_sequencer_datapath.sv
// rtl/exe_muldiv_sequencer_datapath.sv - magnitude accumulator, shift-add / restoring-divide step and sign fix-up
module muldiv_datapath
   import exe_muldiv_sequencer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             iterate_i,
   input  logic             fix_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] val1_i,
   input  logic [WIDTH-1:0] val2_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   // acc holds {partial product, multiplier} for MUL and {rem, quo} for DIV
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q;
   logic               is_div_q, sign_res_q, sign_rem_q, dz_q;
   logic [WIDTH-1:0]   hi_q, lo_q, hi_d, lo_d;

   logic [WIDTH-1:0]   mag1, mag2;
   logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   rem_raw;

   // operand magnitudes, one iteration step and the final sign correction
   always_comb begin
      mag1     = (op_i[0] && val1_i[WIDTH-1]) ? -val1_i : val1_i;
      mag2     = (op_i[0] && val2_i[WIDTH-1]) ? -val2_i : val2_i;
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
      rem_diff = rem_sh - {1'b0, mcand_q};
      acc_d    = acc_q;
      if (is_div_q) begin
         if (!rem_diff[WIDTH])
            acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         else
            acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         // carry out of the add lands in the top bit after the right shift
         acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
      prod_fix = sign_res_q ? -acc_q : acc_q;
      rem_raw  = dz_q ? acc_q[WIDTH-1:0] : acc_q[2*WIDTH-1:WIDTH];
      if (is_div_q) begin
         hi_d = sign_rem_q ? -rem_raw : rem_raw;
         if (dz_q)
            lo_d = '1;
         else
            lo_d = sign_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      end else begin
         hi_d = prod_fix[2*WIDTH-1:WIDTH];
         lo_d = prod_fix[WIDTH-1:0];
      end
   end

   // operand latch on load, one step per iterate, HI/LO write on fix
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q      <= '0;
         mcand_q    <= '0;
         is_div_q   <= 1'b0;
         sign_res_q <= 1'b0;
         sign_rem_q <= 1'b0;
         dz_q       <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else if (load_i) begin
         acc_q      <= {{WIDTH{1'b0}}, mag1};
         mcand_q    <= mag2;
         is_div_q   <= op_i[1];
         sign_res_q <= op_i[0] & (val1_i[WIDTH-1] ^ val2_i[WIDTH-1]);
         sign_rem_q <= op_i[0] & val1_i[WIDTH-1];
         dz_q       <= op_i[1] & (val2_i == '0);
      end else if (iterate_i) begin
         acc_q <= acc_d;
      end else if (fix_i) begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: rtl/exe_muldiv_sequencer.sv
// rtl/exe_muldiv_sequencer.sv - EXE-stage multi-cycle MULT/DIV controller with pipeline stall
module exe_muldiv_sequencer
   import exe_muldiv_sequencer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] val1,
   input  logic [WIDTH-1:0] val2,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t         state_q;
   logic [CW-1:0]  count_q;
   logic           done_q;
   logic           div_zero_q;
   logic           accept;
   logic           iterate;
   logic           fix;

   assign accept  = (state_q == ST_IDLE) && start;
   assign iterate = (state_q == ST_MUL) || (state_q == ST_DIV);
   assign fix     = (state_q == ST_FIX);

   // sequencing FSM: accept, count WIDTH steps, fix signs, retire
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  count_q <= CW'(WIDTH);
                  if (!op[1]) begin
                     state_q <= ST_MUL;
                  end else if (val2 == '0) begin
                     // zero divisor skips the loop entirely
                     state_q    <= ST_FIX;
                     div_zero_q <= 1'b1;
                  end else begin
                     state_q    <= ST_DIV;
                     div_zero_q <= 1'b0;
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               count_q <= count_q - 1'b1;
               if (count_q == CW'(1))
                  state_q <= ST_FIX;
            end
            ST_FIX: begin
               state_q <= ST_DONE;
               done_q  <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // EXE is frozen while the loop runs, so a new start cannot appear here
   a_no_start_while_running: assert property (@(posedge clk) disable iff (rst)
      (state_q == ST_MUL || state_q == ST_DIV || state_q == ST_FIX) |-> !start);

   muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk       (clk),
      .rst       (rst),
      .load_i    (accept),
      .iterate_i (iterate),
      .fix_i     (fix),
      .op_i      (op),
      .val1_i    (val1),
      .val2_i    (val2),
      .hi_o      (hi),
      .lo_o      (lo)
   );

   assign stall    = accept || iterate || fix;
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign div_zero = div_zero_q;

endmodule

// File: tb/tb_exe_muldiv_sequencer.sv
// tb/tb_exe_muldiv_sequencer.sv - self-checking bench for exe_muldiv_sequencer
module tb_exe_muldiv_sequencer;
   import exe_muldiv_sequencer_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    op = 2'b00;
   logic [W-1:0]  val1 = '0;
   logic [W-1:0]  val2 = '0;
   logic          stall, busy, done, div_zero;
   logic [W-1:0]  hi, lo;

   exe_muldiv_sequencer #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .val1     (val1),
      .val2     (val2),
      .stall    (stall),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } vec_t;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // result monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_unexpected: got done=1 expected no pending result");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result_hi", 64'(hi), 64'(e.hi));
            check("result_lo", 64'(lo), 64'(e.lo));
            check("result_div_zero", 64'(div_zero), 64'(e.dz));
         end
      end
   end

   task automatic push_exp(input vec_t v);
      exp_t e;
      e.hi = v.hi;
      e.lo = v.lo;
      e.dz = v.dz;
      sb.push_back(e);
   endtask

   // called on the negedge of cycle lat0; returns on the negedge where done is seen
   task automatic wait_done(input int lat0, output int lat, output int st);
      lat = lat0;
      st = 0;
      while (!done && lat < 200) begin
         if (stall) st++;
         @(negedge clk);
         lat++;
      end
      if (!done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
      end
   endtask

   task automatic run_op(input vec_t v);
      int lat, st, st0, exp_lat;
      @(negedge clk);
      op = v.op; val1 = v.a; val2 = v.b; start = 1'b1;
      push_exp(v);
      #1 st0 = int'(stall);
      @(negedge clk);
      start = 1'b0;
      wait_done(1, lat, st);
      exp_lat = (v.op[1] && v.b == '0) ? 2 : W + 2;
      check("latency", 64'(lat), 64'(exp_lat));
      check("stall_cycles", 64'(st + st0), 64'(exp_lat));
      check("stall_low_in_done", 64'(stall), 64'(0));
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'(0));
      check("idle_after_done", 64'(busy), 64'(0));
   endtask

   initial begin
      int lat, st;
      vec_t a, b;

      vecs.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
      vecs.push_back('{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0});
      vecs.push_back('{OP_MULTU, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB, 1'b0});
      vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
      vecs.push_back('{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0});
      vecs.push_back('{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1});
      vecs.push_back('{OP_DIVU,  32'd9,        32'd3,        32'd0,        32'd3,        1'b0});
      vecs.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
      vecs.push_back('{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0});
      vecs.push_back('{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0});
      vecs.push_back('{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1});
      vecs.push_back('{OP_MULT,  32'd3,        32'd0,        32'd0,        32'd0,        1'b1});
      vecs.push_back('{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0});

      // reset state
      #1;
      check("reset_hi", 64'(hi), 64'(0));
      check("reset_lo", 64'(lo), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_stall", 64'(stall), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      check("reset_div_zero", 64'(div_zero), 64'(0));
      repeat (3) @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) run_op(vecs[i]);

      // reset in the middle of a multiply loop
      @(negedge clk);
      op = OP_MULTU; val1 = 32'hFFFFFFFF; val2 = 32'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("midop_busy_before", 64'(busy), 64'(1));
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midop_rst_busy", 64'(busy), 64'(0));
      check("midop_rst_stall", 64'(stall), 64'(0));
      check("midop_rst_hi", 64'(hi), 64'(0));
      check("midop_rst_lo", 64'(lo), 64'(0));
      check("midop_rst_done", 64'(done), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      a = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
      run_op(a);

      // back-to-back: second start raised in the DONE cycle and held into IDLE
      a = '{OP_MULT, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      b = '{OP_MULT, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};
      @(negedge clk);
      op = a.op; val1 = a.a; val2 = a.b; start = 1'b1;
      push_exp(a);
      @(negedge clk);
      start = 1'b0;
      wait_done(1, lat, st);
      check("b2b_first_latency", 64'(lat), 64'(W + 2));
      op = b.op; val1 = b.a; val2 = b.b; start = 1'b1;
      push_exp(b);
      #1 check("b2b_stall_in_done", 64'(stall), 64'(0));
      @(negedge clk);
      check("b2b_idle_gap", 64'(busy), 64'(0));
      #1 check("b2b_accept_stall", 64'(stall), 64'(1));
      @(negedge clk);
      start = 1'b0;
      check("b2b_accepted", 64'(busy), 64'(1));
      wait_done(1, lat, st);
      check("b2b_second_latency", 64'(lat), 64'(W + 2));
      @(negedge clk);
      check("b2b_done_one_cycle", 64'(done), 64'(0));
      repeat (4) @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
